// File: rtl/fp_seq_control.sv
// Sequencer for a multi-cycle FP unit: decodes funct7, times execution, issues one writeback.
// Optional build macro FP_SEQ_FLUSH_EN adds a flush input that abandons EXEC/WB without writing.
module fp_seq_control #(
  parameter int ADD_LAT  = 2,
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 10,
  parameter int SQRT_LAT = 12
) (
  input  logic       clk,
  input  logic       rst,
`ifdef FP_SEQ_FLUSH_EN
  input  logic       flush,
`endif
  input  logic       valid_in,
  input  logic [6:0] op,
  input  logic [6:0] funct7,
  output logic       stall,
  output logic       fp_start,
  output logic [3:0] FP_alu_op,
  output logic       FP_reg_we,
  output logic       Reg_Write,
  output logic       done,
  output logic       illegal,
  output logic [1:0] dbg_state_o
);

  localparam logic [6:0] OP_FP = 7'b1010011;
  localparam int MAX_AM  = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam int MAX_DS  = (DIV_LAT > SQRT_LAT) ? DIV_LAT : SQRT_LAT;
  localparam int MAX_LAT = (MAX_AM > MAX_DS) ? MAX_AM : MAX_DS;
  localparam int CW      = $clog2(MAX_LAT + 1);

  // The counter is loaded with LAT-1 so that EXEC lasts exactly LAT cycles.
  localparam logic [CW-1:0] ADD_M1  = CW'(ADD_LAT - 1);
  localparam logic [CW-1:0] MUL_M1  = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV_LAT - 1);
  localparam logic [CW-1:0] SQRT_M1 = CW'(SQRT_LAT - 1);
  localparam logic [CW-1:0] ONE_M1  = '0;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [3:0]      alu_op_q;
  logic            stall_q, fp_start_q, fp_we_q, int_we_q, done_q, illegal_q;

  logic            fp_instr;
  logic            dec_legal;
  logic [3:0]      dec_code;
  logic [CW-1:0]   dec_lat_m1;
  logic            wr_int;

  assign fp_instr = valid_in && (op == OP_FP);

  always_comb begin
    dec_legal  = 1'b1;
    dec_code   = 4'd0;
    dec_lat_m1 = ADD_M1;
    case (funct7)
      7'b0000000: begin dec_code = 4'd0;  dec_lat_m1 = ADD_M1;  end
      7'b0000100: begin dec_code = 4'd1;  dec_lat_m1 = ADD_M1;  end
      7'b0001000: begin dec_code = 4'd2;  dec_lat_m1 = MUL_M1;  end
      7'b0001100: begin dec_code = 4'd3;  dec_lat_m1 = DIV_M1;  end
      7'b0101100: begin dec_code = 4'd4;  dec_lat_m1 = SQRT_M1; end
      7'b0010000: begin dec_code = 4'd5;  dec_lat_m1 = ONE_M1;  end
      7'b0010100: begin dec_code = 4'd6;  dec_lat_m1 = ONE_M1;  end
      7'b1010000: begin dec_code = 4'd7;  dec_lat_m1 = ONE_M1;  end
      7'b1100000: begin dec_code = 4'd8;  dec_lat_m1 = ONE_M1;  end
      7'b1101000: begin dec_code = 4'd9;  dec_lat_m1 = ONE_M1;  end
      7'b1110000: begin dec_code = 4'd10; dec_lat_m1 = ONE_M1;  end
      7'b1111000: begin dec_code = 4'd11; dec_lat_m1 = ONE_M1;  end
      default:    dec_legal = 1'b0;
    endcase
  end

  // Compares, classify and moves to integer land write the integer register file.
  assign wr_int = (alu_op_q == 4'd7) || (alu_op_q == 4'd8) || (alu_op_q == 4'd10);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      alu_op_q   <= 4'd0;
      stall_q    <= 1'b0;
      fp_start_q <= 1'b0;
      fp_we_q    <= 1'b0;
      int_we_q   <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      fp_start_q <= 1'b0;
      fp_we_q    <= 1'b0;
      int_we_q   <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      case (state_q)
        IDLE, WB: begin
          if (fp_instr && dec_legal) begin
            state_q    <= EXEC;
            alu_op_q   <= dec_code;
            cnt_q      <= dec_lat_m1;
            fp_start_q <= 1'b1;
            stall_q    <= 1'b1;
          end else begin
            state_q   <= IDLE;
            stall_q   <= 1'b0;
            illegal_q <= fp_instr;
          end
        end
        EXEC: begin
          if (cnt_q == '0) begin
            state_q  <= WB;
            stall_q  <= 1'b0;
            done_q   <= 1'b1;
            int_we_q <= wr_int;
            fp_we_q  <= !wr_int;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          stall_q <= 1'b0;
        end
      endcase
`ifdef FP_SEQ_FLUSH_EN
      // Flush wins over both completion and a new acceptance.
      if (flush && (state_q != IDLE)) begin
        state_q    <= IDLE;
        cnt_q      <= '0;
        stall_q    <= 1'b0;
        fp_start_q <= 1'b0;
        fp_we_q    <= 1'b0;
        int_we_q   <= 1'b0;
        done_q     <= 1'b0;
        illegal_q  <= 1'b0;
      end
`endif
    end
  end

  assign stall       = stall_q;
  assign fp_start    = fp_start_q;
  assign FP_alu_op   = alu_op_q;
  assign FP_reg_we   = fp_we_q;
  assign Reg_Write   = int_we_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fp_seq_control.sv
// Bench for fp_seq_control: directed scenarios plus random instruction streams against a queue model.
module tb_fp_seq_control;
  localparam int ADD_LAT = 2, MUL_LAT = 3, DIV_LAT = 10, SQRT_LAT = 12;
  localparam logic [6:0] OP_FP = 7'b1010011;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic valid_in = 1'b0;
  logic [6:0] op = 7'd0;
  logic [6:0] funct7 = 7'd0;
  logic stall, fp_start, FP_reg_we, Reg_Write, done, illegal;
  logic [3:0] FP_alu_op;
  logic [1:0] dbg_state;
`ifdef FP_SEQ_FLUSH_EN
  logic flush = 1'b0;
`endif

  fp_seq_control #(.ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .SQRT_LAT(SQRT_LAT)) dut (
    .clk(clk), .rst(rst),
`ifdef FP_SEQ_FLUSH_EN
    .flush(flush),
`endif
    .valid_in(valid_in), .op(op), .funct7(funct7),
    .stall(stall), .fp_start(fp_start), .FP_alu_op(FP_alu_op), .FP_reg_we(FP_reg_we),
    .Reg_Write(Reg_Write), .done(done), .illegal(illegal), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // Record per cycle: [10] check op, [9] stall, [8] start, [7] fp we, [6] int we, [5] done, [4] illegal, [3:0] op
  logic [10:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  logic [6:0] f7_tab [12] = '{7'h00, 7'h04, 7'h08, 7'h0C, 7'h2C, 7'h10, 7'h14, 7'h50, 7'h60, 7'h68, 7'h70, 7'h78};
  int lat_tab [12] = '{ADD_LAT, ADD_LAT, MUL_LAT, DIV_LAT, SQRT_LAT, 1, 1, 1, 1, 1, 1, 1};

  // Schedules the expected outputs for every cycle following an acceptance.
  task automatic model_accept(input logic [6:0] f);
    int idx;
    logic [3:0] code;
    logic wint;
    idx = -1;
    for (int i = 0; i < 12; i++) if (f7_tab[i] == f) idx = i;
    if (idx < 0) begin
      exp_q.push_back(11'h010);
    end else begin
      code = 4'(idx);
      wint = (idx == 7) || (idx == 8) || (idx == 10);
      for (int k = 0; k < lat_tab[idx]; k++)
        exp_q.push_back({1'b1, 1'b1, (k == 0), 4'b0000, code});
      exp_q.push_back({1'b1, 1'b0, 1'b0, !wint, wint, 1'b1, 1'b0, code});
    end
  endtask

  // One cycle: sample outputs, pop the expected record, then drive this cycle's inputs.
  task automatic step(input logic v, input logic [6:0] o, input logic [6:0] f,
                      output logic [10:0] e, output logic [10:0] g, output logic acc);
    @(negedge clk);
    g = {1'b0, stall, fp_start, FP_reg_we, Reg_Write, done, illegal, FP_alu_op};
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 11'h000;
    valid_in = v;
    op = o;
    funct7 = f;
    acc = 1'b0;
    if (!e[9] && v && (o == OP_FP)) begin
      acc = 1'b1;
      model_accept(f);
    end
  endtask

  function automatic logic [10:0] cmp_mask(input logic [10:0] e);
    return {1'b0, 6'h3F, e[10] ? 4'hF : 4'h0};
  endfunction

  task automatic test_reset();
    logic [10:0] e, g, m;
    logic acc;
    #1 rst = 1'b1;
    #1;
    g = {1'b0, stall, fp_start, FP_reg_we, Reg_Write, done, illegal, FP_alu_op};
    n_vec++;
    if (g !== 11'h000) begin n_err++; $display("FAIL reset_state got=%h exp=000", g); end
    @(negedge clk);
    rst = 1'b0;
    valid_in = 1'b1; op = OP_FP; funct7 = 7'h50;
    model_accept(7'h50);
    for (int c = 1; c <= 3; c++) begin
      step(1'b0, 7'd0, 7'd0, e, g, acc);
      m = cmp_mask(e);
      n_vec++;
      if ((g & m) !== (e & m)) begin n_err++; $display("FAIL first_accept c=%0d got=%h exp=%h", c, g, e); end
    end
  endtask

  task automatic test_fdiv();
    logic [10:0] e, g, m;
    logic acc;
    step(1'b1, OP_FP, 7'h0C, e, g, acc);
    n_vec++;
    if (acc !== 1'b1) begin n_err++; $display("FAIL fdiv_accept got=%b exp=1", acc); end
    for (int c = 1; c <= 12; c++) begin
      step(1'b0, 7'd0, 7'd0, e, g, acc);
      m = cmp_mask(e);
      n_vec++;
      if ((g & m) !== (e & m)) begin n_err++; $display("FAIL fdiv c=%0d got=%h exp=%h", c, g, e); end
      if (c == 11) begin
        n_vec++;
        if (g[7:0] !== 8'hA3) begin n_err++; $display("FAIL fdiv_wb got=%h exp=a3", g[7:0]); end
      end
    end
  endtask

  task automatic test_feq();
    logic [10:0] e, g, m;
    logic acc;
    step(1'b1, OP_FP, 7'h50, e, g, acc);
    for (int c = 1; c <= 3; c++) begin
      step(1'b0, 7'd0, 7'd0, e, g, acc);
      m = cmp_mask(e);
      n_vec++;
      if ((g & m) !== (e & m)) begin n_err++; $display("FAIL feq c=%0d got=%h exp=%h", c, g, e); end
      if (c == 2) begin
        n_vec++;
        if (g[7:5] !== 3'b011) begin n_err++; $display("FAIL feq_wb we/done got=%b exp=011", g[7:5]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] e, g, m;
    logic acc;
    int wb_cyc;
    wb_cyc = -1;
    step(1'b1, OP_FP, 7'h00, e, g, acc);
    for (int c = 1; c <= 10; c++) begin
      // FMUL is held on the inputs from cycle 1 until it is taken.
      step((wb_cyc < 0), OP_FP, 7'h08, e, g, acc);
      m = cmp_mask(e);
      n_vec++;
      if ((g & m) !== (e & m)) begin n_err++; $display("FAIL b2b c=%0d got=%h exp=%h", c, g, e); end
      if (acc) wb_cyc = c;
    end
    n_vec++;
    if (wb_cyc != ADD_LAT + 1) begin n_err++; $display("FAIL b2b_accept_cycle got=%0d exp=%0d", wb_cyc, ADD_LAT + 1); end
  endtask

  task automatic test_illegal();
    logic [10:0] e, g, m;
    logic acc;
    step(1'b1, OP_FP, 7'h01, e, g, acc);
    for (int c = 1; c <= 3; c++) begin
      step(1'b0, 7'd0, 7'd0, e, g, acc);
      m = cmp_mask(e);
      n_vec++;
      if ((g & m) !== (e & m)) begin n_err++; $display("FAIL illegal c=%0d got=%h exp=%h", c, g, e); end
      if (c == 1) begin
        n_vec++;
        if (g[9:4] !== 6'b000001) begin n_err++; $display("FAIL illegal_pulse got=%b exp=000001", g[9:4]); end
      end
    end
  endtask

  task automatic test_random();
    logic [10:0] e, g, m;
    logic acc, pv, pend;
    logic [6:0] po, pf;
    pend = 1'b0; pv = 1'b0; po = 7'd0; pf = 7'd0;
    for (int i = 0; i < 600; i++) begin
      if (!pend) begin
        pv = ($urandom_range(0, 9) < 7);
        po = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(0, 127)) : OP_FP;
        pf = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : f7_tab[$urandom_range(0, 11)];
      end
      step(pv, po, pf, e, g, acc);
      m = cmp_mask(e);
      n_vec++;
      if ((g & m) !== (e & m)) begin n_err++; $display("FAIL random i=%0d got=%h exp=%h", i, g, e); end
      pend = pv && (po == OP_FP) && !acc;
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 7'd0, 7'd0, e, g, acc);
      m = cmp_mask(e);
      n_vec++;
      if ((g & m) !== (e & m)) begin n_err++; $display("FAIL random_drain i=%0d got=%h exp=%h", i, g, e); end
    end
  endtask

  task automatic test_reset_midflight();
    logic [10:0] e, g, m;
    logic acc;
    step(1'b1, OP_FP, 7'h2C, e, g, acc);
    for (int c = 1; c <= 4; c++) begin
      step(1'b0, 7'd0, 7'd0, e, g, acc);
      m = cmp_mask(e);
      n_vec++;
      if ((g & m) !== (e & m)) begin n_err++; $display("FAIL sqrt_exec c=%0d got=%h exp=%h", c, g, e); end
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    g = {1'b0, stall, fp_start, FP_reg_we, Reg_Write, done, illegal, FP_alu_op};
    n_vec++;
    if (g !== 11'h000) begin n_err++; $display("FAIL async_reset got=%h exp=000", g); end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 16; c++) begin
      step(1'b0, 7'd0, 7'd0, e, g, acc);
      n_vec++;
      if (g !== 11'h000) begin n_err++; $display("FAIL post_reset c=%0d got=%h exp=000", c, g); end
    end
  endtask

`ifdef FP_SEQ_FLUSH_EN
  task automatic test_flush();
    logic [10:0] e, g, m;
    logic acc;
    step(1'b1, OP_FP, 7'h0C, e, g, acc);
    for (int c = 1; c <= 3; c++) begin
      step(1'b0, 7'd0, 7'd0, e, g, acc);
      m = cmp_mask(e);
      n_vec++;
      if ((g & m) !== (e & m)) begin n_err++; $display("FAIL flush_exec c=%0d got=%h exp=%h", c, g, e); end
    end
    flush = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 flush = 1'b0;
    for (int c = 4; c < 16; c++) begin
      step(1'b0, 7'd0, 7'd0, e, g, acc);
      n_vec++;
      if (g[9:4] !== 6'b000000) begin n_err++; $display("FAIL flush_idle c=%0d got=%h exp=0", c, g[9:4]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fdiv();
    test_feq();
    test_back_to_back();
    test_illegal();
    test_random();
    test_reset_midflight();
`ifdef FP_SEQ_FLUSH_EN
    test_flush();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
